// File: rtl/dma_request_arbiter.sv
// Round-robin arbiter sharing one DMA engine between PROC_CNT processors.
// Toggle-style request/ack handshake per processor, latched descriptor, watchdog abort.
module dma_request_arbiter #(
   parameter int PROC_CNT = 4,
   parameter int SIZE     = 4,
   parameter int PROCSIZE = 4,
   parameter int TIMEOUT  = 64
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         enable,
   input  logic [PROC_CNT-1:0]          trigger,
   input  logic [PROC_CNT-1:0]          action,
   input  logic [PROC_CNT*SIZE-1:0]     ptr,
   input  logic [PROC_CNT*PROCSIZE-1:0] copy_start,
   input  logic [PROC_CNT*PROCSIZE-1:0] copy_length,
   output logic [PROC_CNT-1:0]          ack,
   output logic [PROC_CNT-1:0]          pending,
   output logic                         dma_req,
   output logic [$clog2(PROC_CNT)-1:0]  dma_proc,
   output logic                         dma_action,
   output logic [SIZE-1:0]              dma_ptr,
   output logic [PROCSIZE-1:0]          dma_copy_start,
   output logic [PROCSIZE-1:0]          dma_copy_length,
   input  logic                         dma_done,
   output logic                         dma_abort,
   output logic                         error,
   output logic                         busy
);

   localparam int IDX_W = $clog2(PROC_CNT);
   localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam bit WDOG_EN = (TIMEOUT != 0);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PROC_CNT - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

   state_t             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [TMR_W-1:0]   timer;

   logic               sel_found;
   logic [IDX_W-1:0]   sel_idx;
   logic               sel_action;
   logic [SIZE-1:0]    sel_ptr;
   logic [PROCSIZE-1:0] sel_start;
   logic [PROCSIZE-1:0] sel_length;

   function automatic int wrap_idx(input logic [IDX_W-1:0] base, input int k);
      return (int'(base) + k) % PROC_CNT;
   endfunction

   assign pending = trigger ^ ack;
   assign busy    = (state != S_IDLE);

   // First pending requester at or after rr_ptr, together with its live descriptor.
   always_comb begin
      sel_found  = 1'b0;
      sel_idx    = '0;
      sel_action = 1'b0;
      sel_ptr    = '0;
      sel_start  = '0;
      sel_length = '0;
      for (int k = 0; k < PROC_CNT; k++) begin
         if (!sel_found && pending[IDX_W'(wrap_idx(rr_ptr, k))]) begin
            sel_found  = 1'b1;
            sel_idx    = IDX_W'(wrap_idx(rr_ptr, k));
            sel_action = action[IDX_W'(wrap_idx(rr_ptr, k))];
            sel_ptr    = ptr[wrap_idx(rr_ptr, k)*SIZE +: SIZE];
            sel_start  = copy_start[wrap_idx(rr_ptr, k)*PROCSIZE +: PROCSIZE];
            sel_length = copy_length[wrap_idx(rr_ptr, k)*PROCSIZE +: PROCSIZE];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= S_IDLE;
         rr_ptr          <= '0;
         timer           <= '0;
         ack             <= '0;
         dma_req         <= 1'b0;
         dma_proc        <= '0;
         dma_action      <= 1'b0;
         dma_ptr         <= '0;
         dma_copy_start  <= '0;
         dma_copy_length <= '0;
         dma_abort       <= 1'b0;
         error           <= 1'b0;
      end else begin
         dma_abort <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enable && sel_found) begin
                  dma_proc        <= sel_idx;
                  dma_action      <= sel_action;
                  dma_ptr         <= sel_ptr;
                  dma_copy_start  <= sel_start;
                  dma_copy_length <= sel_length;
                  // Zero-length transfers complete immediately without involving the DMA.
                  if (sel_length != '0) begin
                     dma_req <= 1'b1;
                     timer   <= '0;
                     state   <= S_BUSY;
                  end else begin
                     ack[sel_idx] <= ~ack[sel_idx];
                     state        <= S_RELEASE;
                  end
               end
            end
            S_BUSY: begin
               timer <= timer + TMR_W'(1);
               if (dma_done) begin
                  dma_req       <= 1'b0;
                  ack[dma_proc] <= ~ack[dma_proc];
                  state         <= S_RELEASE;
               end else if (WDOG_EN && timer == TMR_LAST) begin
                  dma_req       <= 1'b0;
                  dma_abort     <= 1'b1;
                  error         <= 1'b1;
                  ack[dma_proc] <= ~ack[dma_proc];
                  state         <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               rr_ptr <= (dma_proc == IDX_LAST) ? '0 : dma_proc + IDX_W'(1);
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/dma_request_arbiter.md
Name: dma_request_arbiter

Overview:
Shares the single DMA engine between PROC_CNT processors. Detects each processor's toggle-style transfer request and selects one requester at a time in round-robin order. Presents the latched transfer descriptor to the DMA and holds it until the DMA reports completion. Returns completion to the requester by toggling its ack, and recovers from a hung transfer with a watchdog.

Parameters:
PROC_CNT, 4, number of processors sharing the DMA (>=2)
SIZE, 4, shared-memory address width (ptr)
PROCSIZE, 4, processor-local address/length width
TIMEOUT, 64, max cycles in BUSY before abort; 0 disables the watchdog
(localparam IDX_W = $clog2(PROC_CNT))

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
enable  in  1  permits new grants; an in-flight transfer always finishes
trigger  in  PROC_CNT  per-processor request toggle, same clock domain
action  in  PROC_CNT  per-processor direction: 0 load (SHM->proc), 1 store (proc->SHM)
ptr  in  PROC_CNT*SIZE  flat per-processor SHM pointer, proc i at [i*SIZE +: SIZE]
copy_start  in  PROC_CNT*PROCSIZE  flat per-processor local start address
copy_length  in  PROC_CNT*PROCSIZE  flat per-processor word count
ack  out  PROC_CNT  per-processor completion toggle
pending  out  PROC_CNT  trigger ^ ack (combinational)
dma_req  out  1  descriptor valid; DMA owns transfer while high
dma_proc  out  IDX_W  granted processor index
dma_action  out  1  latched action
dma_ptr  out  SIZE  latched ptr
dma_copy_start  out  PROCSIZE  latched copy_start
dma_copy_length  out  PROCSIZE  latched copy_length
dma_done  in  1  one-cycle completion pulse from DMA
dma_abort  out  1  one-cycle pulse on watchdog expiry
error  out  1  sticky watchdog flag
busy  out  1  high when state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; rr_ptr=0; ack, dma_* outputs, dma_abort, error, timer all 0.
- Request i is pending while trigger[i] != ack[i]. A processor toggles trigger only when not pending.
- FSM states IDLE, BUSY, RELEASE.
- IDLE, enable=1, pending!=0:
  - Select g = first pending index searching rr_ptr, rr_ptr+1, ... mod PROC_CNT.
  - At the next edge, latch dma_proc=g and g's action/ptr/copy_start/copy_length.
  - copy_length!=0: dma_req=1, timer=0, go BUSY.
  - copy_length==0: no dma_req; ack[g] toggles at this edge; go RELEASE.
- IDLE, enable=0 or pending==0: hold.
- BUSY:
  - dma_req and descriptor are held stable; timer increments each cycle.
  - dma_done=1 at an edge: dma_req=0, ack[g] toggles, go RELEASE.
  - TIMEOUT!=0 and timer==TIMEOUT-1 with no done: dma_req=0, dma_abort=1 for one cycle, error=1, ack[g] toggles, go RELEASE.
  - dma_done and expiry in the same cycle: done wins; no abort, no error.
- RELEASE: one cycle. rr_ptr=(g+1) mod PROC_CNT, go IDLE. Guarantees at least one cycle of dma_req=0 between grants.
- dma_done is ignored outside BUSY.
- Changes on trigger/descriptor inputs after the grant are ignored; the latched copy is used.
- A trigger toggling back before its grant withdraws the request (pending clears).
- Latency: trigger toggle at edge T gives dma_req high at edge T+1 when IDLE and rr-first.
- Worst-case wait: (PROC_CNT-1) transfers.
- error clears only on reset.
- Reset mid-BUSY drops dma_req immediately; the DMA must also be reset.

Test Plan:
1. Reset; proc1 toggles trigger 0->1 with action=1, ptr=5, copy_start=2, copy_length=3 -> next edge dma_req=1, dma_proc=1, dma_ptr=5, dma_copy_start=2, dma_copy_length=3; pulse dma_done 5 cycles later -> same edge ack[1]=1, dma_req=0, pending[1]=0; 1 cycle RELEASE then busy=0.
2. Procs 0,2,3 toggle on the same cycle, each completed after 2 cycles -> grant order 0,2,3; proc0 retriggers during proc3's transfer -> granted next; dma_req low at least 1 cycle between grants.
3. Proc2 copy_length=0 -> dma_req never rises; ack[2] toggles one edge after trigger is seen; busy high for exactly 1 cycle (RELEASE).
4. TIMEOUT=8, grant proc0, no dma_done -> after 8 BUSY cycles: dma_abort pulse 1 cycle, error=1, ack[0] toggled, dma_req=0; later done pulses ignored; error stays 1. Repeat with done on the expiry cycle -> error stays 0.
5. enable=0 with proc3 pending -> no grant for 10 cycles; enable=1 -> dma_req next edge with dma_proc=3. enable dropped mid-BUSY -> transfer completes normally.
6. reset_n asserted mid-BUSY -> dma_req, ack, busy go 0 without a clock edge; after release, pending=trigger and arbitration restarts at proc0.
